uart_buffered_if: RTL

Buffered host front-end placed between the TramelBlaze port bus and the existing TX/RX serial engines. It adds a parametrised TX FIFO and RX FIFO, error capture for each received byte, sticky overrun/drop flags, a programmable RX level threshold, and a maskable edge-triggered interrupt. The serial engines and the baud decoder are unchanged and are instantiated alongside this block at the UART top level.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/uart_buffered_if.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ------------------------------------------------------------------
// uart_pkg : shared FSM states and register bit positions for uart_buffered_if
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_BUSY = 2'd1,
    T_DONE = 2'd2
  } tx_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_CLR  = 1'b1
  } rx_state_e;

  localparam int c_ie_rx_avail = 0;
  localparam int c_ie_tx_empty = 1;
  localparam int c_ie_err      = 2;
  localparam logic [2:0] c_ie_reset = 3'b011;

  localparam int c_st_rx_not_empty = 0;
  localparam int c_st_tx_not_full  = 1;
  localparam int c_st_last_p       = 2;
  localparam int c_st_last_f       = 3;
  localparam int c_st_last_ovf     = 4;
  localparam int c_st_rx_overrun   = 5;
  localparam int c_st_tx_drop      = 6;
  localparam int c_st_rx_avail     = 7;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ------------------------------------------------------------------
// sync_fifo : single-clock FIFO with level, full and empty; pop-when-full frees room for a same-cycle push
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0] c_full_lvl = (c_ptr_w + 1)'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w:0]   level_q, level_d;
  logic               do_push, do_pop;

  assign full_o  = (level_q == c_full_lvl);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; the level gates every read of stale entries.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/uart_buffered_if.sv
// ------------------------------------------------------------------
// uart_buffered_if : FIFO-buffered host front-end between the port bus and the UART TX/RX engines
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_buffered_if
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int RX_THRESH = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_data,
  input  logic              write_ctrl,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic              read_data,
  input  logic              read_status,
  output logic [DATA_W-1:0] uart_dout,
  output logic              uart_inter,
  input  logic              eng_tx_rdy,
  output logic              eng_tx_load,
  output logic [DATA_W-1:0] eng_tx_data,
  input  logic              eng_rx_rdy,
  input  logic [DATA_W-1:0] eng_rx_data,
  input  logic              eng_p_err,
  input  logic              eng_f_err,
  input  logic              eng_ovf,
  output logic              eng_rx_clear
);

  localparam int c_rx_w   = DATA_W + 3;
  localparam int c_txl_w  = $clog2(TX_DEPTH) + 1;
  localparam int c_rxl_w  = $clog2(RX_DEPTH) + 1;
  localparam logic [c_rxl_w-1:0] c_thresh = c_rxl_w'(RX_THRESH);

  logic [DATA_W-1:0]  tx_head;
  logic [c_txl_w-1:0] tx_lvl_unused;
  logic               tx_full, tx_empty, tx_pop;
  logic [c_rx_w-1:0]  rx_head;
  logic [c_rxl_w-1:0] rx_lvl;
  logic               rx_full, rx_empty, rx_push, rx_rise;
  logic               rd_data_sel, rd_stat_sel, host_pop, rx_avail;
  logic               tx_drop_set, rx_ovr_set;
  logic [7:0]         status;
  logic [2:0]         cond;

  tx_state_e          tx_state_q, tx_state_d;
  rx_state_e          rx_state_q, rx_state_d;
  logic               tx_load_q, tx_load_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               rx_rdy_q;
  logic               tx_drop_q, tx_drop_d;
  logic               rx_overrun_q, rx_overrun_d;
  logic [2:0]         last_err_q, last_err_d;
  logic [2:0]         ie_q, ie_d;
  logic [2:0]         cond_q;
  logic               inter_q, inter_d;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(clock), .rst_n_i(reset), .push_i(write_data), .pop_i(tx_pop),
    .din_i(write_data_in), .dout_o(tx_head), .level_o(tx_lvl_unused),
    .full_o(tx_full), .empty_o(tx_empty)
  );

  sync_fifo #(.WIDTH(c_rx_w), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(clock), .rst_n_i(reset), .push_i(rx_push), .pop_i(host_pop),
    .din_i({eng_ovf, eng_f_err, eng_p_err, eng_rx_data}), .dout_o(rx_head),
    .level_o(rx_lvl), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign rd_data_sel = read_data & ~read_status;
  assign rd_stat_sel = read_status & ~read_data;
  assign host_pop    = rd_data_sel & ~rx_empty;
  assign rx_avail    = (rx_lvl >= c_thresh);
  assign rx_rise     = eng_rx_rdy & ~rx_rdy_q;
  assign tx_drop_set = write_data & tx_full & ~tx_pop;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_load_d  = 1'b0;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      T_IDLE: if (!tx_empty && eng_tx_rdy) begin
        tx_data_d  = tx_head;
        tx_load_d  = 1'b1;
        tx_pop     = 1'b1;
        tx_state_d = T_BUSY;
      end
      T_BUSY:  if (!eng_tx_rdy) tx_state_d = T_DONE;
      T_DONE:  if (eng_tx_rdy) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_push    = 1'b0;
    rx_ovr_set = 1'b0;
    case (rx_state_q)
      R_IDLE: if (rx_rise) begin
        rx_state_d = R_CLR;
        if (!rx_full || host_pop) rx_push = 1'b1;
        else                      rx_ovr_set = 1'b1;
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  assign eng_rx_clear = (rx_state_q == R_CLR);
  assign eng_tx_load  = tx_load_q;
  assign eng_tx_data  = tx_data_q;
  assign uart_inter   = inter_q;

  // A sticky flag raised in the same cycle as a status read survives the clear.
  always_comb begin
    tx_drop_d    = (tx_drop_q & ~rd_stat_sel) | tx_drop_set;
    rx_overrun_d = (rx_overrun_q & ~rd_stat_sel) | rx_ovr_set;
    last_err_d   = host_pop ? rx_head[c_rx_w-1:DATA_W] : last_err_q;
    ie_d         = write_ctrl ? write_data_in[2:0] : ie_q;

    cond                = '0;
    cond[c_ie_rx_avail] = rx_avail;
    cond[c_ie_tx_empty] = tx_empty & (tx_state_q == T_IDLE);
    cond[c_ie_err]      = tx_drop_q | rx_overrun_q | (|last_err_q);
    inter_d             = |(ie_q & cond & ~cond_q);

    status                    = '0;
    status[c_st_rx_not_empty] = ~rx_empty;
    status[c_st_tx_not_full]  = ~tx_full;
    status[c_st_last_p]       = last_err_q[0];
    status[c_st_last_f]       = last_err_q[1];
    status[c_st_last_ovf]     = last_err_q[2];
    status[c_st_rx_overrun]   = rx_overrun_q;
    status[c_st_tx_drop]      = tx_drop_q;
    status[c_st_rx_avail]     = rx_avail;

    uart_dout = '0;
    if (host_pop)         uart_dout = rx_head[DATA_W-1:0];
    else if (rd_stat_sel) uart_dout = DATA_W'(status);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state_q   <= T_IDLE;
      rx_state_q   <= R_IDLE;
      tx_load_q    <= 1'b0;
      tx_data_q    <= '0;
      rx_rdy_q     <= 1'b0;
      tx_drop_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
      last_err_q   <= '0;
      ie_q         <= c_ie_reset;
      cond_q       <= '0;
      inter_q      <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      rx_state_q   <= rx_state_d;
      tx_load_q    <= tx_load_d;
      tx_data_q    <= tx_data_d;
      rx_rdy_q     <= eng_rx_rdy;
      tx_drop_q    <= tx_drop_d;
      rx_overrun_q <= rx_overrun_d;
      last_err_q   <= last_err_d;
      ie_q         <= ie_d;
      cond_q       <= cond;
      inter_q      <= inter_d;
    end
  end

endmodule

`default_nettype wire
